dfe_prl: RTL and testbench
==========================

DFE_PRL -- requirements
Module: dfe_prl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rstn.
REQ-002 Parameter PULSE_RESPONSE_LENGTH, default 3, SHALL set the number of pulse-response taps: one main cursor plus PULSE_RESPONSE_LENGTH-1 post-cursors.
REQ-003 Parameter SIGNAL_RESOLUTION, default 8, SHALL set the signal width as two's-complement signed.
REQ-004 Parameter SYMBOL_SEPERATION, default 56, SHALL set the spacing between adjacent PAM-4 levels.
REQ-005 Ports SHALL be as follows.
- clk  input  1  clock.
- rstn  input  1  async active-low reset.
- signal_in  input  SIGNAL_RESOLUTION  received sample carrying ISI.
- signal_in_valid  input  1  signal_in qualifier.
- signal_out  output  SIGNAL_RESOLUTION  equalized sample.
- signal_out_valid  output  1  signal_out qualifier.

Function
REQ-006 PAM-4 levels SHALL be -3S/2, -S/2, +S/2, +3S/2, where S = SYMBOL_SEPERATION; at S=56 these are -84, -28, 28, 84.
REQ-007 Post-cursor taps h1..h(L-1) SHALL be unsigned constants in 1/256 units; the defaults are h1=64 (0.25) and h2=32 (0.125).
REQ-008 Per valid sample, ISI SHALL be the sum over k of (d[n-k]*hk)>>>8, using an arithmetic shift on each product with no rounding; d[n-k] is the decided level k samples back.
REQ-009 Internally, y SHALL be signal_in - ISI, computed at width SIGNAL_RESOLUTION+4.
REQ-010 y SHALL saturate to the range [-2^(R-1), 2^(R-1)-1], where R = SIGNAL_RESOLUTION, i.e. [-128, 127] at R=8.
REQ-011 The slicer SHALL produce decision d[n] from saturated y using these rules.
- y < -S gives -3S/2.
- -S <= y < 0 gives -S/2.
- 0 <= y < S gives +S/2.
- y >= S gives +3S/2.
REQ-012 d[n] SHALL enter the decision history on the same clock edge that registers y, so the feedback loop closes within one cycle.
REQ-013 signal_out SHALL equal saturated y, registered with latency 1 cycle; signal_out_valid SHALL be signal_in_valid delayed by 1 cycle.
REQ-014 With signal_in_valid low, the history SHALL NOT shift, signal_out SHALL hold its value, and signal_out_valid SHALL be 0 on the next cycle.
REQ-015 Back-to-back valid samples SHALL be accepted every cycle; there is no backpressure.
REQ-016 History entries not yet written since reset SHALL be 0 and SHALL contribute no ISI.

Reset
REQ-017 Asserting rstn low SHALL immediately clear signal_out to 0, signal_out_valid to 0 and all history entries to 0.
REQ-018 Reset asserted mid-stream SHALL discard all history; the first valid sample after release SHALL be equalized with zero ISI.
REQ-019 No output SHALL change while rstn is low, regardless of signal_in_valid.

Structure
REQ-020 A shared package SHALL hold the following.
- PAM-4 level constants.
- Slicer thresholds.
- The post-cursor tap array, in 1/256 units, indexed 1..L-1.
- The saturation helper function.
REQ-021 The channel model SHALL use the same tap array so that channel and equalizer are matched.
REQ-022 The slicer SHALL be a combinational sub-module, pam4_slicer, instantiated once inside dfe_prl.

Verification
REQ-023 Reset then constant 115 valid every cycle -> outputs 115, 94, then 84 steady from the third valid output onward; signal_out_valid follows input valid 1 cycle later.
REQ-024 Single valid sample 84 after reset -> signal_out=84, valid=1 one cycle later; next output with no valid input -> valid=0, signal_out holds 84.
REQ-025 Input 127 with history 84,84 -> y=96, signal_out=96, d=84.
REQ-026 Input -128 with history +84,+84 -> y=-159 saturates to signal_out=-128, d=-84.
REQ-027 Slicer boundaries with zero history: inputs -57, -56, -1, 0, 55, 56 -> decisions -84, -28, -28, 28, 28, 84.
REQ-028 End-to-end: PRBS31 through gray, PAM-4, matched ISI channel, dfe_prl, decode and checker for 1 ms at 50 MHz -> zero bit errors with no noise.

Source files
------------

// File: rtl/dfe_prl_pkg.sv
// Shared constants and helpers for the PAM-4 decision-feedback equalizer.
//   - PAM-4 level constants at the default symbol separation
//   - slicer threshold and level helpers, parameterised by separation
//   - post-cursor tap table (1/256 units, indexed 1..NUM_POST)
//   - two's-complement saturation helper
// The same tap table drives the equalizer and any channel model, so the two
// stay matched.
package dfe_prl_pkg;

   localparam int DEF_SEP = 56;

   localparam int LVL_P3 = (3 * DEF_SEP) / 2;
   localparam int LVL_P1 = DEF_SEP / 2;
   localparam int LVL_N1 = -LVL_P1;
   localparam int LVL_N3 = -LVL_P3;

   localparam int NUM_POST = 2;
   localparam int unsigned POST_TAP [1:NUM_POST] = '{64, 32};

   // Taps beyond the table are zero, so a longer PULSE_RESPONSE_LENGTH
   // simply adds inactive history.
   function automatic int unsigned post_tap(input int k);
      if (k >= 1 && k <= NUM_POST) return POST_TAP[k];
      return 0;
   endfunction

   function automatic int outer_level(input int sep);
      return (3 * sep) / 2;
   endfunction

   function automatic int inner_level(input int sep);
      return sep / 2;
   endfunction

   function automatic int thr_hi(input int sep);
      return sep;
   endfunction

   function automatic int thr_lo(input int sep);
      return -sep;
   endfunction

   // Clamp v into the r-bit signed range.
   function automatic int sat_signed(input int v, input int r);
      int hi;
      int lo;
      hi = (1 << (r - 1)) - 1;
      lo = -(1 << (r - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dfe_prl_slicer.sv
// pam4_slicer: combinational PAM-4 decision device.
//   y_i  saturated equalized sample (signed, R bits)
//   d_o  nearest PAM-4 level (signed, R bits)
module pam4_slicer
   import dfe_prl_pkg::*;
#(
   parameter int SIGNAL_RESOLUTION = 8,
   parameter int SYMBOL_SEPERATION = 56
) (
   input  logic signed [SIGNAL_RESOLUTION-1:0] y_i,
   output logic signed [SIGNAL_RESOLUTION-1:0] d_o
);

   localparam int R   = SIGNAL_RESOLUTION;
   localparam int OUT = outer_level(SYMBOL_SEPERATION);
   localparam int INN = inner_level(SYMBOL_SEPERATION);
   localparam int THH = thr_hi(SYMBOL_SEPERATION);
   localparam int THL = thr_lo(SYMBOL_SEPERATION);

   int y_int;

   always_comb begin
      y_int = int'(y_i);
      d_o   = R'(OUT);
      if (y_int < THL)      d_o = R'(-OUT);
      else if (y_int < 0)   d_o = R'(-INN);
      else if (y_int < THH) d_o = R'(INN);
   end

endmodule

// File: rtl/dfe_prl.sv
// dfe_prl: PAM-4 decision-feedback equalizer with a single-cycle feedback loop.
//   clk               clock
//   rstn              asynchronous active-low reset
//   signal_in         received sample with ISI (signed)
//   signal_in_valid   signal_in qualifier
//   signal_out        equalized, saturated sample, 1-cycle latency
//   signal_out_valid  signal_in_valid delayed by one cycle
// The decision for the current sample is written into the history on the
// same edge that registers signal_out, so the next sample already sees it.
module dfe_prl
   import dfe_prl_pkg::*;
#(
   parameter int PULSE_RESPONSE_LENGTH = 3,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int SYMBOL_SEPERATION     = 56
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
   input  logic                                signal_in_valid,
   output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
   output logic                                signal_out_valid
);

   localparam int R  = SIGNAL_RESOLUTION;
   localparam int YW = R + 4;
   localparam int PW = R + 12;
   localparam int NH = (PULSE_RESPONSE_LENGTH > 1) ? PULSE_RESPONSE_LENGTH - 1 : 1;
   localparam int NT = PULSE_RESPONSE_LENGTH - 1;

   logic signed [R-1:0]  hist_q [1:NH];
   logic signed [R-1:0]  out_q;
   logic                 vld_q;

   logic signed [YW-1:0] isi;
   logic signed [YW-1:0] y_full;
   logic signed [R-1:0]  y_sat;
   logic signed [R-1:0]  dec;

   logic signed [PW-1:0] h_ext;
   logic signed [PW-1:0] t_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_sh;

   // Each product is floored on its own (arithmetic shift, no rounding)
   // before accumulation.
   always_comb begin
      isi     = '0;
      h_ext   = '0;
      t_ext   = '0;
      prod    = '0;
      prod_sh = '0;
      for (int k = 1; k <= NH; k++) begin
         h_ext   = PW'(hist_q[k]);
         t_ext   = (k <= NT) ? $signed(PW'(post_tap(k))) : '0;
         prod    = h_ext * t_ext;
         prod_sh = prod >>> 8;
         isi     = isi + YW'(prod_sh);
      end
      y_full = YW'(signal_in) - isi;
      y_sat  = R'(sat_signed(int'(y_full), R));
   end

   pam4_slicer #(
      .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
      .SYMBOL_SEPERATION (SYMBOL_SEPERATION)
   ) u_slicer (
      .y_i (y_sat),
      .d_o (dec)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q <= '0;
         vld_q <= 1'b0;
         for (int k = 1; k <= NH; k++) hist_q[k] <= '0;
      end else begin
         vld_q <= signal_in_valid;
         if (signal_in_valid) begin
            out_q     <= y_sat;
            hist_q[1] <= dec;
            for (int k = NH; k >= 2; k--) hist_q[k] <= hist_q[k-1];
         end
      end
   end

   assign signal_out       = out_q;
   assign signal_out_valid = vld_q;

endmodule

// File: tb/tb_dfe_prl.sv
module tb_dfe_prl;
   import dfe_prl_pkg::*;

   logic              clk;
   logic              rstn;
   logic signed [7:0] signal_in;
   logic              signal_in_valid;
   logic signed [7:0] signal_out;
   logic              signal_out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   dfe_prl #(
      .PULSE_RESPONSE_LENGTH (3),
      .SIGNAL_RESOLUTION     (8),
      .SYMBOL_SEPERATION     (56)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .signal_in        (signal_in),
      .signal_in_valid  (signal_in_valid),
      .signal_out       (signal_out),
      .signal_out_valid (signal_out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit do_rst;
      bit vld;
      int din;
      bit exp_vld;
      int exp_out;
   } vec_t;

   vec_t vecs [0:31];
   int   nvec;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input bit r, input bit v, input int x, input bit ev, input int eo);
      vecs[nvec] = '{do_rst: r, vld: v, din: x, exp_vld: ev, exp_out: eo};
      nvec++;
   endtask

   // Called 1 time unit after a rising edge; reset is pulsed well clear of it.
   task automatic pulse_reset();
      rstn = 1'b0;
      #2;
      check("rst_out", int'(signal_out), 0);
      check("rst_vld", int'(signal_out_valid), 0);
      rstn = 1'b1;
   endtask

   task automatic step(input int x, input bit v);
      signal_in       = 8'(x);
      signal_in_valid = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ch_a1, ch_a2, a, x, lvl;

      nvec = 0;
      // constant 115 stream, then idle, then saturation/sign corners
      add(1, 1,  115, 1,  115);
      add(0, 1,  115, 1,   94);
      add(0, 1,  115, 1,   84);
      add(0, 1,  115, 1,   84);
      add(0, 0,    0, 0,   84);
      add(0, 1,  127, 1,   96);
      add(0, 1, -128, 1, -128);
      add(0, 1,    0, 1,   11);
      // single sample then idle
      add(1, 1,   84, 1,   84);
      add(0, 0,    0, 0,   84);
      // slicer boundaries: the second sample exposes the decision through -h1*d
      add(1, 1,  -57, 1,  -57);
      add(0, 1,    0, 1,   21);
      add(1, 1,  -56, 1,  -56);
      add(0, 1,    0, 1,    7);
      add(1, 1,   -1, 1,   -1);
      add(0, 1,    0, 1,    7);
      add(1, 1,    0, 1,    0);
      add(0, 1,    0, 1,   -7);
      add(1, 1,   55, 1,   55);
      add(0, 1,    0, 1,   -7);
      add(1, 1,   56, 1,   56);
      add(0, 1,    0, 1,  -21);

      rstn            = 1'b0;
      signal_in       = '0;
      signal_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("por_out", int'(signal_out), 0);
      check("por_vld", int'(signal_out_valid), 0);
      rstn = 1'b1;

      for (int i = 0; i < nvec; i++) begin
         if (vecs[i].do_rst) pulse_reset();
         step(vecs[i].din, vecs[i].vld);
         check($sformatf("vec%0d_vld", i), int'(signal_out_valid), int'(vecs[i].exp_vld));
         check($sformatf("vec%0d_out", i), int'(signal_out), vecs[i].exp_out);
      end

      // Mid-stream reset: build history, hold reset over active valid input.
      step(115, 1);
      step(115, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_out_now", int'(signal_out), 0);
      check("midrst_vld_now", int'(signal_out_valid), 0);
      signal_in       = 8'sd100;
      signal_in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_out_held", int'(signal_out), 0);
      check("midrst_vld_held", int'(signal_out_valid), 0);
      rstn = 1'b1;
      step(50, 1);
      check("postrst_out", int'(signal_out), 50);
      check("postrst_vld", int'(signal_out_valid), 1);
      step(0, 0);

      // End-to-end: random PAM-4 symbols through a matched ISI channel.
      pulse_reset();
      ch_a1 = 0;
      ch_a2 = 0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            step(0, 0);
            check("e2e_idle_vld", int'(signal_out_valid), 0);
         end else begin
            lvl = int'($urandom_range(0, 3));
            case (lvl)
               0:       a = LVL_N3;
               1:       a = LVL_N1;
               2:       a = LVL_P1;
               default: a = LVL_P3;
            endcase
            x = a + ((ch_a1 * int'(post_tap(1))) >>> 8)
                  + ((ch_a2 * int'(post_tap(2))) >>> 8);
            step(x, 1);
            check("e2e_out", int'(signal_out), a);
            ch_a2 = ch_a1;
            ch_a1 = a;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
